// File: rtl/wave_mix_pkg.sv
// Shared constants and width helpers for the wave mixer.
// Imported by the scaler and the top-level mixer.
package wave_mix_pkg;

    // Input-to-output latency in clocks (scale, sum, output).
    localparam int LAT = 3;

    // Width of the overflow event counter.
    localparam int OVF_CNT_W = 16;

    // Ceiling log2 for elaboration-time width math.
    function automatic int clog2i(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Lossless width of a sum of ch scaled samples of w+1 bits.
    function automatic int sum_w(input int w, input int ch);
        return w + 1 + clog2i(ch);
    endfunction

endpackage

// File: rtl/wave_scale.sv
// Single-channel gain stage: signed sample times unsigned Q1.x
// gain, floored back to sample scale, registered on load.
module wave_scale
    import wave_mix_pkg::*;
#(
    parameter int W      = 16,
    parameter int GAIN_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic signed [W-1:0] sample,
    input  logic [GAIN_W-1:0]   gain,
    input  logic                en,
    output logic signed [W:0]   p_q
);

    localparam int MW = W + GAIN_W;

    logic signed [MW-1:0] a_x;
    logic signed [MW-1:0] g_x;
    logic signed [MW-1:0] prod;
    logic signed [W:0]    p_d;

    // Full-precision product, then floor-shift out the fraction.
    always_comb begin
        a_x  = MW'(sample);
        g_x  = MW'(gain);
        prod = a_x * g_x;
        p_d  = p_q;
        if (load) begin
            if (en) begin
                p_d = (W + 1)'(prod >>> (GAIN_W - 1));
            end else begin
                p_d = '0;
            end
        end
    end

    // Scaled-sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/wave_mixer.sv
// Multi-channel mixer: per-channel gain, lossless sum, then
// saturate or wrap to W bits with sticky overflow tracking.
module wave_mixer
    import wave_mix_pkg::*;
#(
    parameter int CH     = 4,
    parameter int W      = 16,
    parameter int GAIN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [CH*W-1:0]        q_in,
    input  logic [CH-1:0]          ch_en,
    input  logic [CH*GAIN_W-1:0]   gain,
    input  logic                   sat_en,
    input  logic                   clr_ovf,
    output logic [W-1:0]           q_out,
    output logic                   out_valid,
    output logic                   ovf,
    output logic [OVF_CNT_W-1:0]   ovf_cnt
);

    localparam int SW = sum_w(W, CH);

    logic [LAT-1:0]        v_q;
    logic [LAT-1:0]        v_d;
    logic signed [W:0]     p_q [CH];
    logic signed [SW-1:0]  s_q;
    logic signed [SW-1:0]  s_d;
    logic [W-1:0]          out_q;
    logic [W-1:0]          out_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic [OVF_CNT_W-1:0]  cnt_q;
    logic [OVF_CNT_W-1:0]  cnt_d;
    logic [SW-W:0]         s_hi;
    logic                  s_oor;
    logic                  ovf_evt;

    // Stage 1: one scaler per channel, loaded with the input set.
    for (genvar k = 0; k < CH; k++) begin : g_ch
        wave_scale #(
            .W      (W),
            .GAIN_W (GAIN_W)
        ) u_scale (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (in_valid),
            .sample (q_in[k*W +: W]),
            .gain   (gain[k*GAIN_W +: GAIN_W]),
            .en     (ch_en[k]),
            .p_q    (p_q[k])
        );
    end

    // Valid bits march one stage per clock, no stalls.
    always_comb begin
        v_d = {v_q[LAT-2:0], in_valid};
    end

    // Stage 2: sign-extended sum of all scaled channels.
    always_comb begin
        s_d = s_q;
        if (v_q[0]) begin
            s_d = '0;
            for (int k = 0; k < CH; k++) begin
                s_d = s_d + SW'(p_q[k]);
            end
        end
    end

    // Sum fits W bits only when all bits from W-1 up agree.
    always_comb begin
        s_hi    = s_q[SW-1:W-1];
        s_oor   = !((&s_hi) || (~|s_hi));
        ovf_evt = v_q[1] && s_oor;
    end

    // Stage 3: clamp or keep low bits, sat_en taken here.
    always_comb begin
        out_d = out_q;
        if (v_q[1]) begin
            if (sat_en && s_oor) begin
                if (s_q[SW-1]) begin
                    out_d = {1'b1, {(W-1){1'b0}}};
                end else begin
                    out_d = {1'b0, {(W-1){1'b1}}};
                end
            end else begin
                out_d = s_q[W-1:0];
            end
        end
    end

    // Sticky flag and saturating counter; a new event wins over clear.
    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (clr_ovf) begin
            ovf_d = ovf_evt;
            cnt_d = ovf_evt ? OVF_CNT_W'(1) : '0;
        end else if (ovf_evt) begin
            ovf_d = 1'b1;
            if (cnt_q != {OVF_CNT_W{1'b1}}) begin
                cnt_d = cnt_q + OVF_CNT_W'(1);
            end
        end
    end

    // Pipeline, output and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            s_q   <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            s_q   <= s_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_out     = out_q;
    assign out_valid = v_q[LAT-1];
    assign ovf       = ovf_q;
    assign ovf_cnt   = cnt_q;

endmodule
